// File: rtl/panic_desc_gen_pkg.sv
// panic_desc_gen_pkg: descriptor field widths, FSM state type and field bundle
package panic_desc_gen_pkg;

    localparam int PRIO_SIZE  = 8;
    localparam int CHAIN_SIZE = 16;
    localparam int TIME_SIZE  = 16;
    localparam int LEN_SIZE   = 16;
    localparam int FLOW_SIZE  = 8;

    typedef enum logic {
        ST_START,
        ST_BODY
    } state_e;

    typedef struct packed {
        logic [PRIO_SIZE-1:0]  prio;
        logic [CHAIN_SIZE-1:0] chain;
        logic [TIME_SIZE-1:0]  tstamp;
        logic [LEN_SIZE-1:0]   pk_len;
        logic [FLOW_SIZE-1:0]  flow_id;
    } desc_fields_t;

endpackage

// File: rtl/panic_desc_fifo.sv
// panic_desc_fifo: synchronous first-word-fall-through FIFO with full/empty/count
module panic_desc_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           din_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           dout_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_q, rd_q;
    logic [AW:0]      cnt_q;
    logic             do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign dout_o  = empty_o ? '0 : mem_q[rd_q];

    // storage write; contents need no reset because the head is masked when empty
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_q] <= din_i;
    end

    // pointers and occupancy; a simultaneous push and pop leaves the count unchanged
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) wr_q <= wr_q + AW'(1);
            if (do_pop) rd_q <= rd_q + AW'(1);
            if (do_push && !do_pop) cnt_q <= cnt_q + (AW+1)'(1);
            else if (do_pop && !do_push) cnt_q <= cnt_q - (AW+1)'(1);
        end
    end

endmodule

// File: rtl/panic_desc_gen.sv
// panic_desc_gen: gates ingress into the parser, measures packets and queues descriptors
module panic_desc_gen
    import panic_desc_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 256,
    parameter int KEEP_WIDTH = DATA_WIDTH/8,
    parameter int FIFO_DEPTH = 4,
    parameter int ID_WIDTH   = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  p_axis_tvalid,
    output logic                  p_axis_tlast,
    output logic                  desc_req,
    output logic                  desc_next,
    input  logic [PRIO_SIZE-1:0]  p_desc_prio,
    input  logic [CHAIN_SIZE-1:0] p_desc_chain,
    input  logic [TIME_SIZE-1:0]  p_desc_time,
    input  logic [LEN_SIZE-1:0]   p_desc_pk_len,
    input  logic [FLOW_SIZE-1:0]  p_desc_flow_id,
    output logic                  m_desc_valid,
    input  logic                  m_desc_ready,
    output logic [PRIO_SIZE-1:0]  m_desc_prio,
    output logic [CHAIN_SIZE-1:0] m_desc_chain,
    output logic [TIME_SIZE-1:0]  m_desc_time,
    output logic [LEN_SIZE-1:0]   m_desc_pk_len,
    output logic [FLOW_SIZE-1:0]  m_desc_flow_id,
    output logic [LEN_SIZE-1:0]   m_desc_byte_cnt,
    output logic                  m_desc_err,
    output logic [ID_WIDTH-1:0]   m_desc_id
);

    typedef struct packed {
        desc_fields_t          f;
        logic [LEN_SIZE-1:0]   byte_cnt;
        logic                  err;
        logic [ID_WIDTH-1:0]   id;
    } entry_t;

    localparam int ENTRY_W = $bits(entry_t);

    function automatic logic [LEN_SIZE-1:0] popcount(input logic [KEEP_WIDTH-1:0] keep);
        popcount = '0;
        for (int i = 0; i < KEEP_WIDTH; i++) popcount += {{(LEN_SIZE-1){1'b0}}, keep[i]};
    endfunction

    state_e                  state_q, state_d;
    desc_fields_t            hold_q, hold_d, p_fields, cur_fields;
    logic [LEN_SIZE-1:0]     cnt_q, cnt_d;
    logic [LEN_SIZE:0]       sum;
    logic [ID_WIDTH-1:0]     id_q, id_d;
    logic                    accept, first, push, full, empty;
    entry_t                  push_entry, head;
    logic [$clog2(FIFO_DEPTH):0] unused_count;
    logic                    unused_tdata;

    assign unused_tdata  = ^s_axis_tdata;
    assign s_axis_tready = !full;
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign first         = state_q == ST_START;
    assign desc_req      = accept && first;
    assign desc_next     = desc_req;
    assign p_axis_tvalid = accept;
    assign p_axis_tlast  = s_axis_tlast;
    assign push          = accept && s_axis_tlast;
    assign m_desc_valid  = !empty;

    // packet-boundary tracking: a first beat is expected after reset and after every tlast
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_START;
        else state_q <= state_d;
    end

    // next state only advances on accepted beats
    always_comb begin
        state_d = state_q;
        if (accept) state_d = s_axis_tlast ? ST_START : ST_BODY;
    end

    // parser fields are valid only on the first beat, so single-beat packets bypass the hold regs
    always_comb begin
        p_fields   = '{prio: p_desc_prio, chain: p_desc_chain, tstamp: p_desc_time,
                       pk_len: p_desc_pk_len, flow_id: p_desc_flow_id};
        cur_fields = first ? p_fields : hold_q;
        hold_d     = desc_req ? p_fields : hold_q;
        sum        = {1'b0, first ? {LEN_SIZE{1'b0}} : cnt_q} + {1'b0, popcount(s_axis_tkeep)};
        cnt_d      = accept ? (sum[LEN_SIZE] ? {LEN_SIZE{1'b1}} : sum[LEN_SIZE-1:0]) : cnt_q;
        id_d       = push ? id_q + ID_WIDTH'(1) : id_q;
        push_entry = '{f: cur_fields, byte_cnt: cnt_d, err: cnt_d != cur_fields.pk_len, id: id_q};
    end

    // captured fields, running byte count and packet sequence id
    always_ff @(posedge clk) begin
        if (rst) begin
            hold_q <= '0;
            cnt_q  <= '0;
            id_q   <= '0;
        end else begin
            hold_q <= hold_d;
            cnt_q  <= cnt_d;
            id_q   <= id_d;
        end
    end

    panic_desc_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (m_desc_valid && m_desc_ready),
        .dout_o  (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (unused_count)
    );

    assign m_desc_prio     = head.f.prio;
    assign m_desc_chain    = head.f.chain;
    assign m_desc_time     = head.f.tstamp;
    assign m_desc_pk_len   = head.f.pk_len;
    assign m_desc_flow_id  = head.f.flow_id;
    assign m_desc_byte_cnt = head.byte_cnt;
    assign m_desc_err      = head.err;
    assign m_desc_id       = head.id;

endmodule

// File: tb/tb_panic_desc_gen.sv
// tb_panic_desc_gen: randomized packet traffic checked against a packet-level descriptor model
module tb_panic_desc_gen;
    import panic_desc_gen_pkg::*;

    localparam int DW = 256;
    localparam int KW = DW/8;
    localparam int FD = 4;
    localparam int IW = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic s_axis_tvalid = 1'b0, s_axis_tlast = 1'b0, s_axis_tready;
    logic p_axis_tvalid, p_axis_tlast, desc_req, desc_next;
    logic [PRIO_SIZE-1:0]  p_desc_prio = '0;
    logic [CHAIN_SIZE-1:0] p_desc_chain = '0;
    logic [TIME_SIZE-1:0]  p_desc_time = '0;
    logic [LEN_SIZE-1:0]   p_desc_pk_len = '0;
    logic [FLOW_SIZE-1:0]  p_desc_flow_id = '0;
    logic m_desc_valid, m_desc_ready = 1'b0;
    logic [PRIO_SIZE-1:0]  m_desc_prio;
    logic [CHAIN_SIZE-1:0] m_desc_chain;
    logic [TIME_SIZE-1:0]  m_desc_time;
    logic [LEN_SIZE-1:0]   m_desc_pk_len;
    logic [FLOW_SIZE-1:0]  m_desc_flow_id;
    logic [LEN_SIZE-1:0]   m_desc_byte_cnt;
    logic m_desc_err;
    logic [IW-1:0] m_desc_id;

    always #5 clk = ~clk;

    panic_desc_gen #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .FIFO_DEPTH(FD), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tlast(s_axis_tlast), .s_axis_tready(s_axis_tready),
        .p_axis_tvalid(p_axis_tvalid), .p_axis_tlast(p_axis_tlast),
        .desc_req(desc_req), .desc_next(desc_next),
        .p_desc_prio(p_desc_prio), .p_desc_chain(p_desc_chain), .p_desc_time(p_desc_time),
        .p_desc_pk_len(p_desc_pk_len), .p_desc_flow_id(p_desc_flow_id),
        .m_desc_valid(m_desc_valid), .m_desc_ready(m_desc_ready),
        .m_desc_prio(m_desc_prio), .m_desc_chain(m_desc_chain), .m_desc_time(m_desc_time),
        .m_desc_pk_len(m_desc_pk_len), .m_desc_flow_id(m_desc_flow_id),
        .m_desc_byte_cnt(m_desc_byte_cnt), .m_desc_err(m_desc_err), .m_desc_id(m_desc_id)
    );

    typedef struct {
        logic [PRIO_SIZE-1:0]  prio;
        logic [CHAIN_SIZE-1:0] chain;
        logic [TIME_SIZE-1:0]  tm;
        logic [LEN_SIZE-1:0]   len;
        logic [FLOW_SIZE-1:0]  flow;
        logic [LEN_SIZE-1:0]   cnt;
        logic                  err;
        logic [IW-1:0]         id;
    } desc_t;

    desc_t q[$];
    desc_t cur;
    logic [IW-1:0] id_m = '0;
    bit first_m = 1'b0;
    bit last_acc = 1'b0;
    int ready_pct = 100;
    int n_cmp = 0, n_bad = 0;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic rand_p();
        p_desc_prio    = PRIO_SIZE'($urandom);
        p_desc_chain   = CHAIN_SIZE'($urandom);
        p_desc_time    = TIME_SIZE'($urandom);
        p_desc_pk_len  = LEN_SIZE'($urandom);
        p_desc_flow_id = FLOW_SIZE'($urandom);
    endtask

    // one clock: inputs are already applied; check outputs, advance the model, wait for next negedge
    task automatic cycle();
        bit exp_rdy, acc;
        desc_t h;
        m_desc_ready = ($urandom_range(99) < ready_pct);
        #1;
        exp_rdy = q.size() < FD;
        acc = s_axis_tvalid && exp_rdy;
        check("tready", s_axis_tready, exp_rdy);
        check("p_tvalid", p_axis_tvalid, acc);
        check("p_tlast", p_axis_tlast, s_axis_tlast);
        check("desc_req", desc_req, acc && first_m);
        check("desc_next", desc_next, acc && first_m);
        check("m_valid", m_desc_valid, q.size() != 0);
        if (q.size() != 0) begin
            h = q[0];
            check("id", m_desc_id, h.id);
            check("byte_cnt", m_desc_byte_cnt, h.cnt);
            check("err", m_desc_err, h.err);
            check("pk_len", m_desc_pk_len, h.len);
            check("fields", {m_desc_prio, m_desc_chain, m_desc_time, m_desc_flow_id},
                  {h.prio, h.chain, h.tm, h.flow});
            if (m_desc_ready) void'(q.pop_front());
        end else begin
            check("empty_zero", {m_desc_prio, m_desc_chain, m_desc_time, m_desc_pk_len,
                  m_desc_flow_id, m_desc_byte_cnt, m_desc_err, m_desc_id}, 128'd0);
        end
        if (acc && s_axis_tlast) begin
            h = cur;
            h.id = id_m;
            id_m++;
            q.push_back(h);
        end
        last_acc = acc;
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        s_axis_tvalid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        q.delete();
        id_m = '0;
    endtask

    task automatic drain();
        s_axis_tvalid = 1'b0;
        ready_pct = 100;
        repeat (6) cycle();
    endtask

    task automatic send_pkt(input int nb, input logic [KW-1:0] kl,
                            input logic [PRIO_SIZE-1:0] pr, input logic [CHAIN_SIZE-1:0] ch,
                            input logic [TIME_SIZE-1:0] tm, input logic [LEN_SIZE-1:0] ln,
                            input logic [FLOW_SIZE-1:0] fl, input bit gaps, input int rst_at);
        longint b;
        int i, tries;
        b = longint'(nb - 1) * KW + $countones(kl);
        cur.prio = pr; cur.chain = ch; cur.tm = tm; cur.len = ln; cur.flow = fl;
        cur.cnt = (b > 65535) ? 16'hFFFF : 16'(b);
        cur.err = cur.cnt != ln;
        i = 0;
        tries = 0;
        while (i < nb) begin
            tries++;
            if (tries > 5000) begin
                check("stall_bound", s_axis_tready, 1'b1);
                break;
            end
            first_m = (i == 0);
            s_axis_tdata = {8{$urandom()}};
            if (gaps && $urandom_range(3) == 0) begin
                s_axis_tvalid = 1'b0;
                s_axis_tlast = 1'($urandom);
                s_axis_tkeep = KW'($urandom);
                rand_p();
                cycle();
                continue;
            end
            s_axis_tvalid = 1'b1;
            s_axis_tkeep = (i == nb - 1) ? kl : '1;
            s_axis_tlast = (i == nb - 1);
            if (i == 0) begin
                p_desc_prio = pr; p_desc_chain = ch; p_desc_time = tm;
                p_desc_pk_len = ln; p_desc_flow_id = fl;
            end else rand_p();
            if (i == rst_at) begin
                do_reset();
                return;
            end
            cycle();
            if (last_acc) i++;
        end
        s_axis_tvalid = 1'b0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        cycle();
        cycle();
        // four-beat packet: 3 full beats plus 4 bytes = 100
        send_pkt(4, 32'h0000000F, 8'd50, 16'h0000, 16'h1234, 16'd100, 8'd2, 1'b0, -1);
        drain();
        // single-beat packet, 20 bytes measured against a 32-byte length
        send_pkt(1, 32'h000FFFFF, 8'd7, 16'h0006, 16'h0042, 16'd32, 8'd1, 1'b0, -1);
        drain();
        // full FIFO with the scheduler stalled, then a blocked first beat
        do_reset();
        ready_pct = 0;
        for (int k = 0; k < 4; k++)
            send_pkt(1, 32'h1, 8'(k), 16'(k), 16'(k), 16'd1, 8'(k), 1'b0, -1);
        first_m = 1'b1;
        s_axis_tvalid = 1'b1;
        s_axis_tkeep = 32'h1;
        s_axis_tlast = 1'b1;
        rand_p();
        repeat (5) cycle();
        ready_pct = 100;
        send_pkt(1, 32'h1, 8'd4, 16'd4, 16'd4, 16'd1, 8'd4, 1'b0, -1);
        drain();
        // steady state at occupancy 3 with continuous push and pop
        ready_pct = 0;
        for (int k = 0; k < 3; k++)
            send_pkt(1, KW'($urandom) | 32'h1, 8'(k), 16'(k), 16'(k), 16'(k), 8'(k), 1'b0, -1);
        ready_pct = 100;
        for (int k = 0; k < 20; k++)
            send_pkt(1, KW'($urandom) | 32'h1, 8'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom_range(32)), 8'($urandom), 1'b0, -1);
        drain();
        // reset on beat 2 of a 4-beat packet with descriptors queued
        ready_pct = 0;
        send_pkt(1, 32'hFF, 8'd1, 16'd1, 16'd1, 16'd8, 8'd1, 1'b0, -1);
        send_pkt(1, 32'hFF, 8'd2, 16'd2, 16'd2, 16'd8, 8'd2, 1'b0, -1);
        send_pkt(4, '1, 8'd3, 16'd3, 16'd3, 16'd128, 8'd3, 1'b0, 2);
        ready_pct = 100;
        send_pkt(2, 32'h0000FFFF, 8'd9, 16'd9, 16'd9, 16'd48, 8'd9, 1'b1, -1);
        drain();
        // byte count saturation on a very long packet
        send_pkt(2100, '1, 8'd5, 16'd5, 16'd5, 16'hFFFF, 8'd5, 1'b0, -1);
        drain();
        // random traffic with gaps and random scheduler backpressure
        ready_pct = 60;
        for (int k = 0; k < 40; k++) begin
            int nb;
            logic [KW-1:0] kl;
            logic [LEN_SIZE-1:0] ln;
            nb = $urandom_range(1, 5);
            kl = KW'($urandom) | 32'h1;
            ln = ($urandom_range(1) == 0) ? 16'((nb - 1) * KW + $countones(kl)) : 16'($urandom_range(200));
            send_pkt(nb, kl, 8'($urandom), 16'($urandom), 16'($urandom), ln, 8'($urandom), 1'b1, -1);
        end
        drain();
        // id wrap: packet 256 after reset carries id 0
        do_reset();
        ready_pct = 70;
        for (int k = 0; k < 300; k++)
            send_pkt(1, KW'($urandom) | 32'h1, 8'($urandom), 16'($urandom), 16'($urandom),
                     16'($urandom_range(32)), 8'($urandom), 1'b0, -1);
        drain();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
